// File: rtl/ddr4_cmd_packer.sv
// rtl/ddr4_cmd_packer.sv - packs decoded DDR4 SoftMC instructions into NCK_PER_CLK DFI phase slots
module ddr4_cmd_packer #(
  parameter int NCK_PER_CLK = 4,
  parameter int ROW_WIDTH   = 17,
  parameter int BANK_WIDTH  = 2,
  parameter int BG_WIDTH    = 2,
  parameter int WAIT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              instr_valid,
  input  logic [31:0]                       instr,
  output logic                              instr_ready,
  input  logic                              flush,
  output logic                              dfi_valid,
  output logic [ROW_WIDTH*NCK_PER_CLK-1:0]  dfi_address,
  output logic [BANK_WIDTH*NCK_PER_CLK-1:0] dfi_bank,
  output logic [BG_WIDTH*NCK_PER_CLK-1:0]   dfi_bg,
  output logic [NCK_PER_CLK-1:0]            dfi_act_n,
  output logic [NCK_PER_CLK-1:0]            dfi_ras_n,
  output logic [NCK_PER_CLK-1:0]            dfi_cas_n,
  output logic [NCK_PER_CLK-1:0]            dfi_we_n,
  output logic [NCK_PER_CLK-1:0]            dfi_cs_n,
  output logic [NCK_PER_CLK-1:0]            mc_rd_cas,
  output logic [NCK_PER_CLK-1:0]            mc_wr_cas
);

  localparam int PTR_W = $clog2(NCK_PER_CLK + 1);
  localparam int AW    = ROW_WIDTH * NCK_PER_CLK;
  localparam int BW    = BANK_WIDTH * NCK_PER_CLK;
  localparam int GW    = BG_WIDTH * NCK_PER_CLK;
  localparam logic [NCK_PER_CLK-1:0] ONES = {NCK_PER_CLK{1'b1}};

  typedef enum logic {S_FILL = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                  r_state;
  logic [PTR_W-1:0]        r_ptr;
  logic [WAIT_WIDTH-1:0]   r_cnt;
  logic                    r_ready;

  logic [AW-1:0]           r_addr;
  logic [BW-1:0]           r_bank;
  logic [GW-1:0]           r_bg;
  logic [NCK_PER_CLK-1:0]  r_act, r_ras, r_cas, r_we, r_cs, r_rd, r_wr;

  logic                    r_dfi_valid;
  logic [AW-1:0]           r_dfi_addr;
  logic [BW-1:0]           r_dfi_bank;
  logic [GW-1:0]           r_dfi_bg;
  logic [NCK_PER_CLK-1:0]  r_dfi_act, r_dfi_ras, r_dfi_cas, r_dfi_we, r_dfi_cs, r_dfi_rd, r_dfi_wr;

  logic                    w_acc, w_is_ddr, w_is_wait, w_is_act, w_emit, w_unused;
  logic [WAIT_WIDTH-1:0]   w_wait_n;
  logic [PTR_W-1:0]        w_ptr_nxt;
  logic [ROW_WIDTH-1:0]    w_s_addr;
  logic [BANK_WIDTH-1:0]   w_s_bank;
  logic [BG_WIDTH-1:0]     w_s_bg;
  logic                    w_s_act, w_s_ras, w_s_cas, w_s_we, w_s_cs, w_s_rd, w_s_wr;
  logic [AW-1:0]           w_addr;
  logic [BW-1:0]           w_bank;
  logic [GW-1:0]           w_bg;
  logic [NCK_PER_CLK-1:0]  w_act, w_ras, w_cas, w_we, w_cs, w_rd, w_wr;

  assign instr_ready = r_ready & en;
  assign w_acc       = instr_valid & instr_ready;
  assign w_is_ddr    = w_acc & (instr[31:29] == 3'b001);
  assign w_is_wait   = w_acc & (instr[31:29] == 3'b010);
  assign w_wait_n    = instr[WAIT_WIDTH-1:0];
  assign w_unused    = ^instr[20:17];

  // ACT reuses the ras/cas/we pins as row address bits 16..14
  assign w_is_act = ~instr[27] & instr[26] & instr[25];
  assign w_s_act  = ~w_is_act;
  assign w_s_ras  = w_is_act ? instr[16] : instr[27];
  assign w_s_cas  = w_is_act ? instr[15] : instr[26];
  assign w_s_we   = w_is_act ? instr[14] : instr[25];
  assign w_s_cs   = instr[28];
  assign w_s_rd   = ~instr[28] & instr[27] & ~instr[26] & instr[25];
  assign w_s_wr   = ~instr[28] & instr[27] & ~instr[26] & ~instr[25];
  assign w_s_addr = instr[ROW_WIDTH-1:0];
  assign w_s_bank = BANK_WIDTH'(instr[22:21]);
  assign w_s_bg   = BG_WIDTH'(instr[24:23]);

  always_comb begin
    w_addr = r_addr;
    w_bank = r_bank;
    w_bg   = r_bg;
    w_act  = r_act;
    w_ras  = r_ras;
    w_cas  = r_cas;
    w_we   = r_we;
    w_cs   = r_cs;
    w_rd   = r_rd;
    w_wr   = r_wr;
    for (int i = 0; i < NCK_PER_CLK; i++) begin
      if (w_is_ddr && (r_ptr == PTR_W'(i))) begin
        w_addr[i*ROW_WIDTH +: ROW_WIDTH]   = w_s_addr;
        w_bank[i*BANK_WIDTH +: BANK_WIDTH] = w_s_bank;
        w_bg[i*BG_WIDTH +: BG_WIDTH]       = w_s_bg;
        w_act[i] = w_s_act;
        w_ras[i] = w_s_ras;
        w_cas[i] = w_s_cas;
        w_we[i]  = w_s_we;
        w_cs[i]  = w_s_cs;
        w_rd[i]  = w_s_rd;
        w_wr[i]  = w_s_wr;
      end
    end
  end

  assign w_ptr_nxt = r_ptr + PTR_W'(w_is_ddr);
  // The instruction accepted this clk counts toward the word before any flush decision
  assign w_emit = (r_state == S_FILL) &
                  ((w_ptr_nxt == PTR_W'(NCK_PER_CLK)) |
                   ((flush | w_is_wait) & (w_ptr_nxt != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_addr      <= '0;
      r_bank      <= '0;
      r_bg        <= '0;
      r_act       <= ONES;
      r_ras       <= ONES;
      r_cas       <= ONES;
      r_we        <= ONES;
      r_cs        <= ONES;
      r_rd        <= '0;
      r_wr        <= '0;
      r_dfi_valid <= 1'b0;
      r_dfi_addr  <= '0;
      r_dfi_bank  <= '0;
      r_dfi_bg    <= '0;
      r_dfi_act   <= ONES;
      r_dfi_ras   <= ONES;
      r_dfi_cas   <= ONES;
      r_dfi_we    <= ONES;
      r_dfi_cs    <= ONES;
      r_dfi_rd    <= '0;
      r_dfi_wr    <= '0;
    end else begin
      r_dfi_valid <= 1'b0;
      r_dfi_addr  <= '0;
      r_dfi_bank  <= '0;
      r_dfi_bg    <= '0;
      r_dfi_act   <= ONES;
      r_dfi_ras   <= ONES;
      r_dfi_cas   <= ONES;
      r_dfi_we    <= ONES;
      r_dfi_cs    <= ONES;
      r_dfi_rd    <= '0;
      r_dfi_wr    <= '0;
      case (r_state)
        S_FILL: begin
          r_ready <= 1'b1;
          if (w_emit) begin
            r_dfi_valid <= 1'b1;
            r_dfi_addr  <= w_addr;
            r_dfi_bank  <= w_bank;
            r_dfi_bg    <= w_bg;
            r_dfi_act   <= w_act;
            r_dfi_ras   <= w_ras;
            r_dfi_cas   <= w_cas;
            r_dfi_we    <= w_we;
            r_dfi_cs    <= w_cs;
            r_dfi_rd    <= w_rd;
            r_dfi_wr    <= w_wr;
            r_ptr       <= '0;
            r_addr      <= '0;
            r_bank      <= '0;
            r_bg        <= '0;
            r_act       <= ONES;
            r_ras       <= ONES;
            r_cas       <= ONES;
            r_we        <= ONES;
            r_cs        <= ONES;
            r_rd        <= '0;
            r_wr        <= '0;
          end else begin
            r_ptr  <= w_ptr_nxt;
            r_addr <= w_addr;
            r_bank <= w_bank;
            r_bg   <= w_bg;
            r_act  <= w_act;
            r_ras  <= w_ras;
            r_cas  <= w_cas;
            r_we   <= w_we;
            r_cs   <= w_cs;
            r_rd   <= w_rd;
            r_wr   <= w_wr;
          end
          if (w_is_wait && (w_wait_n != '0)) begin
            r_state <= S_WAIT;
            r_cnt   <= w_wait_n;
            r_ready <= 1'b0;
          end
        end
        S_WAIT: begin
          r_dfi_valid <= 1'b1;
          r_cnt       <= r_cnt - WAIT_WIDTH'(1);
          if (r_cnt == WAIT_WIDTH'(1)) begin
            r_state <= S_FILL;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign dfi_valid   = r_dfi_valid;
  assign dfi_address = r_dfi_addr;
  assign dfi_bank    = r_dfi_bank;
  assign dfi_bg      = r_dfi_bg;
  assign dfi_act_n   = r_dfi_act;
  assign dfi_ras_n   = r_dfi_ras;
  assign dfi_cas_n   = r_dfi_cas;
  assign dfi_we_n    = r_dfi_we;
  assign dfi_cs_n    = r_dfi_cs;
  assign mc_rd_cas   = r_dfi_rd;
  assign mc_wr_cas   = r_dfi_wr;

endmodule

// File: tb/tb_ddr4_cmd_packer.sv
// tb/tb_ddr4_cmd_packer.sv - scoreboard bench driving a 4-slot/17-bit and a 2-slot/15-bit packer in lockstep
module tb_ddr4_cmd_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        instr_valid;
  logic [31:0] instr;
  logic        flush;

  logic        d4_ready, d4_valid;
  logic [67:0] d4_addr;
  logic [7:0]  d4_bank, d4_bg;
  logic [3:0]  d4_act, d4_ras, d4_cas, d4_we, d4_cs, d4_rd, d4_wr;

  logic        d2_ready, d2_valid;
  logic [29:0] d2_addr;
  logic [3:0]  d2_bank, d2_bg;
  logic [1:0]  d2_act, d2_ras, d2_cas, d2_we, d2_cs, d2_rd, d2_wr;

  always #5 clk = ~clk;

  ddr4_cmd_packer #(.NCK_PER_CLK(4), .ROW_WIDTH(17)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(d4_ready), .flush(flush), .dfi_valid(d4_valid), .dfi_address(d4_addr),
    .dfi_bank(d4_bank), .dfi_bg(d4_bg), .dfi_act_n(d4_act), .dfi_ras_n(d4_ras),
    .dfi_cas_n(d4_cas), .dfi_we_n(d4_we), .dfi_cs_n(d4_cs), .mc_rd_cas(d4_rd), .mc_wr_cas(d4_wr)
  );

  ddr4_cmd_packer #(.NCK_PER_CLK(2), .ROW_WIDTH(15)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(d2_ready), .flush(flush), .dfi_valid(d2_valid), .dfi_address(d2_addr),
    .dfi_bank(d2_bank), .dfi_bg(d2_bg), .dfi_act_n(d2_act), .dfi_ras_n(d2_ras),
    .dfi_cas_n(d2_cas), .dfi_we_n(d2_we), .dfi_cs_n(d2_cs), .mc_rd_cas(d2_rd), .mc_wr_cas(d2_wr)
  );

  typedef struct packed {
    logic [67:0] addr;
    logic [7:0]  bank;
    logic [7:0]  bg;
    logic [3:0]  act, ras, cas, we, cs, rd, wr;
  } word_t;

  int    n_vec = 0;
  int    n_err = 0;
  word_t q4[$];
  word_t q2[$];
  word_t pend[2];
  int    pcnt[2];
  word_t g4, g2;

  task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic word_t nop_word(input int k);
    word_t w;
    int nk;
    w  = '0;
    nk = (k == 0) ? 4 : 2;
    for (int i = 0; i < nk; i++) begin
      w.act[i] = 1'b1;
      w.ras[i] = 1'b1;
      w.cas[i] = 1'b1;
      w.we[i]  = 1'b1;
      w.cs[i]  = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [31:0] mk_ddr(input logic cs, input logic ras, input logic cas,
                                         input logic we, input logic [1:0] bg,
                                         input logic [1:0] ba, input logic [16:0] a);
    return {3'b001, cs, ras, cas, we, bg, ba, 4'b0000, a};
  endfunction

  function automatic logic [31:0] mk_wait(input logic [15:0] n);
    return {3'b010, 13'h0, n};
  endfunction

  task automatic push_exp(input int k, input word_t w);
    if (k == 0) q4.push_back(w);
    else        q2.push_back(w);
  endtask

  task automatic model_reset(input int k);
    pend[k] = nop_word(k);
    pcnt[k] = 0;
  endtask

  task automatic model_flush(input int k);
    if (pcnt[k] != 0) begin
      push_exp(k, pend[k]);
      model_reset(k);
    end
  endtask

  task automatic model_ddr(input int k, input logic [31:0] ins);
    int   p, rw, nk;
    logic c, r, s, w, is_act;
    rw = (k == 0) ? 17 : 15;
    nk = (k == 0) ? 4 : 2;
    p  = pcnt[k];
    c  = ins[28];
    r  = ins[27];
    s  = ins[26];
    w  = ins[25];
    is_act = !r && s && w;
    for (int b = 0; b < rw; b++) pend[k].addr[p*rw+b] = ins[b];
    pend[k].bank[p*2 +: 2] = ins[22:21];
    pend[k].bg[p*2 +: 2]   = ins[24:23];
    pend[k].act[p] = !is_act;
    pend[k].ras[p] = is_act ? ins[16] : r;
    pend[k].cas[p] = is_act ? ins[15] : s;
    pend[k].we[p]  = is_act ? ins[14] : w;
    pend[k].cs[p]  = c;
    pend[k].rd[p]  = !c && r && !s && w;
    pend[k].wr[p]  = !c && r && !s && !w;
    pcnt[k] = p + 1;
    if (pcnt[k] == nk) begin
      push_exp(k, pend[k]);
      model_reset(k);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic fl);
    int budget;
    budget = 0;
    while (!d4_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!d4_ready) begin
      check("ready_timeout", 112'(d4_ready), 112'(1));
    end else begin
      instr_valid = 1'b1;
      instr       = ins;
      flush       = fl;
      for (int k = 0; k < 2; k++) begin
        if (ins[31:29] == 3'b001) model_ddr(k, ins);
        if (ins[31:29] == 3'b010) begin
          model_flush(k);
          for (int j = 0; j < int'(ins[15:0]); j++) push_exp(k, nop_word(k));
        end
        if (fl) model_flush(k);
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
      flush       = 1'b0;
    end
  endtask

  task automatic mon(input int k, input logic v, input word_t g);
    word_t e;
    if (v) begin
      if ((k == 0 && q4.size() == 0) || (k == 1 && q2.size() == 0)) begin
        check($sformatf("spurious_valid%0d", k), 112'(v), 112'(0));
      end else begin
        if (k == 0) e = q4.pop_front();
        else        e = q2.pop_front();
        check($sformatf("addr%0d", k), 112'(g.addr), 112'(e.addr));
        check($sformatf("bank%0d", k), 112'(g.bank), 112'(e.bank));
        check($sformatf("bg%0d", k),   112'(g.bg),   112'(e.bg));
        check($sformatf("pins%0d", k),
              112'({g.act, g.ras, g.cas, g.we, g.cs, g.rd, g.wr}),
              112'({e.act, e.ras, e.cas, e.we, e.cs, e.rd, e.wr}));
      end
    end else begin
      check($sformatf("idle_nop%0d", k), g, nop_word(k));
    end
  endtask

  always @(negedge clk) begin
    g4 = '0;
    g4.addr = d4_addr; g4.bank = d4_bank; g4.bg = d4_bg;
    g4.act = d4_act; g4.ras = d4_ras; g4.cas = d4_cas; g4.we = d4_we;
    g4.cs = d4_cs; g4.rd = d4_rd; g4.wr = d4_wr;
    mon(0, d4_valid, g4);
    g2 = '0;
    g2.addr[29:0] = d2_addr; g2.bank[3:0] = d2_bank; g2.bg[3:0] = d2_bg;
    g2.act[1:0] = d2_act; g2.ras[1:0] = d2_ras; g2.cas[1:0] = d2_cas; g2.we[1:0] = d2_we;
    g2.cs[1:0] = d2_cs; g2.rd[1:0] = d2_rd; g2.wr[1:0] = d2_wr;
    mon(1, d2_valid, g2);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] i_act, i_rd, i_wr, i_pre;
    int          budget;
    rst = 1'b1; en = 1'b1; instr_valid = 1'b0; instr = '0; flush = 1'b0;
    model_reset(0);
    model_reset(1);
    i_act = mk_ddr(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 17'h1C005);
    i_rd  = mk_ddr(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 17'h00040);
    i_wr  = mk_ddr(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 17'h00123);
    i_pre = mk_ddr(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 17'h00400);

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid4", 112'(d4_valid), 112'(0));
    check("rst_ready4", 112'(d4_ready), 112'(0));
    check("rst_ready2", 112'(d2_ready), 112'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 112'(d4_ready), 112'(1));

    // back-to-back ACT/RD/WR/PRE
    send(i_act, 1'b0);
    send(i_rd, 1'b0);
    send(i_wr, 1'b0);
    check("t1_no_early_valid", 112'(d4_valid), 112'(0));
    send(i_pre, 1'b0);
    check("t1_valid", 112'(d4_valid), 112'(1));
    check("t1_s0_act_n", 112'(d4_act[0]), 112'(0));
    check("t2_s0_pins", 112'({d4_ras[0], d4_cas[0], d4_we[0]}), 112'(3'b111));
    check("t2_s0_addr", 112'(d4_addr[16:0]), 112'(17'h1C005));
    check("t1_s1_rd", 112'(d4_rd[1]), 112'(1));
    check("t1_s2_wr", 112'(d4_wr[2]), 112'(1));
    check("t1_s3_ras_we", 112'({d4_ras[3], d4_we[3]}), 112'(2'b00));
    @(posedge clk); #1;
    check("t1_one_pulse", 112'(d4_valid), 112'(0));

    // two DDR instrs then WAIT 3
    send(i_act, 1'b0);
    send(i_rd, 1'b0);
    send(mk_wait(16'd3), 1'b0);
    check("t3_partial_valid", 112'(d4_valid), 112'(1));
    check("t3_ready0_a", 112'({d4_ready, d2_ready}), 112'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("t3_nop_valid_%0d", i), 112'({d4_valid, d2_valid}), 112'(2'b11));
      check($sformatf("t3_ready_%0d", i), 112'({d4_ready, d2_ready}), (i == 2) ? 112'(2'b11) : 112'(0));
    end
    @(posedge clk); #1;
    check("t3_wait_done", 112'(d4_valid), 112'(0));

    // accept + flush, then flush with empty word
    send(i_rd, 1'b1);
    check("t4_flush_valid", 112'(d4_valid), 112'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("t4_empty_flush", 112'({d4_valid, d2_valid}), 112'(0));

    // unknown type consumed, en low mid-fill, WAIT 0 acts as flush
    send({3'b111, 29'h0ABCDEF}, 1'b0);
    send(i_act, 1'b0);
    en = 1'b0;
    #1;
    check("en_low_ready", 112'(d4_ready), 112'(0));
    instr_valid = 1'b1;
    instr       = i_pre;
    repeat (3) @(posedge clk);
    #1;
    instr_valid = 1'b0;
    en = 1'b1;
    send(i_wr, 1'b0);
    send(mk_wait(16'd0), 1'b0);
    check("wait0_partial", 112'(d4_valid), 112'(1));
    check("wait0_ready", 112'(d4_ready), 112'(1));

    // reset in the middle of WAIT 5
    send(mk_wait(16'd5), 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    q4.delete();
    q2.delete();
    model_reset(0);
    model_reset(1);
    #1;
    check("t5_valid", 112'({d4_valid, d2_valid}), 112'(0));
    check("t5_ready", 112'({d4_ready, d2_ready}), 112'(0));
    check("t5_act_nop", 112'(d4_act), 112'(4'hF));
    check("t5_addr_nop", 112'(d4_addr), 112'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_ready_after", 112'({d4_ready, d2_ready}), 112'(2'b11));
    send(i_wr, 1'b1);

    budget = 0;
    while ((q4.size() != 0 || q2.size() != 0) && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain4", 112'(q4.size()), 112'(0));
    check("drain2", 112'(q2.size()), 112'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
